// File: rtl/ifu_cache_ctrl_pkg.sv
// Shared types and sizing for the IFU instruction-cache controller and its
// replacement-policy block.
package ifu_cache_ctrl_pkg;

  localparam int WAYS_NUM      = 16;
  localparam int ADDR_W        = 32;
  localparam int LINE_W        = 128;
  localparam int WORD_W        = 32;
  localparam int LINE_OFFSET_W = 4;
  localparam int TAG_W         = ADDR_W - LINE_OFFSET_W;
  localparam int WAY_IDX_W     = $clog2(WAYS_NUM);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    MISS_WAIT,
    FILL
  } t_ifu_ctrl_state;

  // Control bundle sent to the replacement block on every lookup outcome.
  typedef struct packed {
    logic                 update_tree;
    logic                 update_counter;
    logic                 cache_miss;
    logic [WAY_IDX_W-1:0] hit_cl;
  } t_cache_ctrl2_plru;

  // Extract one 32-bit instruction word from a line; word 0 sits in the LSBs.
  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        sel);
    return line[int'(sel)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/ifu_cache_ctrl_plru.sv
// Replacement block: tree pseudo-LRU over WAYS_NUM ways plus a cold-fill
// counter. Until every way has been filled once the victim is simply the next
// unused way; after that the tree picks the least-recently-touched half at
// each level. Tree node n has children 2n+1 (lower ways) and 2n+2 (upper ways);
// a node bit of 0 points the victim search at the lower half.
module ifu_cache_ctrl_plru
  import ifu_cache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  t_cache_ctrl2_plru    ctrl,
  output logic [WAY_IDX_W-1:0] evicted_cl
);

  localparam int NODE_W = $clog2(WAYS_NUM - 1);

  logic [WAYS_NUM-2:0]  tree_q;
  logic [WAYS_NUM-2:0]  tree_d;
  logic [WAY_IDX_W:0]   fill_cnt_q;
  logic [WAY_IDX_W-1:0] tree_victim;
  logic                 cold_done;

  assign cold_done = fill_cnt_q[WAY_IDX_W];

  // Follow the stored direction bits from the root down to a leaf.
  always_comb begin
    logic [NODE_W-1:0] node;
    tree_victim = '0;
    node        = '0;
    for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      tree_victim[WAY_IDX_W-1-lvl] = tree_q[node];
      node = NODE_W'(2 * int'(node) + 1 + int'(tree_q[node]));
    end
  end

  // Point every node on the touched way's path away from that way.
  always_comb begin
    logic [NODE_W-1:0] node;
    tree_d = tree_q;
    node   = '0;
    for (int lvl = 0; lvl < WAY_IDX_W; lvl++) begin
      tree_d[node] = ~ctrl.hit_cl[WAY_IDX_W-1-lvl];
      node = NODE_W'(2 * int'(node) + 1 + int'(ctrl.hit_cl[WAY_IDX_W-1-lvl]));
    end
  end

  // Tree and cold-fill counter state; the counter saturates once all ways are used.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree_q     <= '0;
      fill_cnt_q <= '0;
    end else begin
      if (ctrl.update_tree) begin
        tree_q <= tree_d;
      end
      if (ctrl.update_counter && ctrl.cache_miss && !cold_done) begin
        fill_cnt_q <= fill_cnt_q + (WAY_IDX_W + 1)'(1);
      end
    end
  end

  assign evicted_cl = cold_done ? tree_victim : fill_cnt_q[WAY_IDX_W-1:0];

endmodule

// File: rtl/ifu_cache_ctrl.sv
// Fully-associative instruction-cache controller between the fetch stage and
// the memory fabric. One request in flight; misses refill a whole line in a
// single memory beat into the way chosen by the replacement block.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a fetch; applies flush / pending flush
// LOOKUP    | hit: response and plru pulse visible; miss: capture victim
// MISS_REQ  | line request held on the mem side until accepted
// MISS_WAIT | waiting for the refill beat; writes the victim way
// FILL      | response from the new line plus plru pulse
module ifu_cache_ctrl
  import ifu_cache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [ADDR_W-1:0] core_req_addr,
  output logic              core_rsp_valid,
  output logic [WORD_W-1:0] core_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [LINE_W-1:0] mem_rsp_data
);

  t_ifu_ctrl_state      state_q;
  logic [TAG_W-1:0]     tag_q  [WAYS_NUM];
  logic [LINE_W-1:0]    data_q [WAYS_NUM];
  logic [WAYS_NUM-1:0]  valid_q;
  logic                 flush_pending_q;
  logic [TAG_W-1:0]     req_tag_q;
  logic [1:0]           req_word_q;
  logic                 lookup_hit_q;
  logic [WAY_IDX_W-1:0] victim_q;
  t_cache_ctrl2_plru    plru_ctrl;
  logic [WAY_IDX_W-1:0] evicted_cl;

  logic [TAG_W-1:0]     req_tag;
  logic                 hit;
  logic [WAY_IDX_W-1:0] hit_idx;
  logic                 fill_write;
  logic                 unused_addr_bits;

  assign req_tag          = core_req_addr[ADDR_W-1:LINE_OFFSET_W];
  assign unused_addr_bits = ^core_req_addr[1:0];
  assign core_req_ready   = (state_q == IDLE) && !flush && !flush_pending_q;
  assign fill_write       = (state_q == MISS_WAIT) && mem_rsp_valid;

  // Tag compare across all ways. A tag is only ever written into one way, so
  // at most one way matches and OR-ing the indices encodes the hit way.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int w = 0; w < WAYS_NUM; w++) begin
      if (valid_q[w] && (tag_q[w] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = hit_idx | WAY_IDX_W'(w);
      end
    end
  end

  // Controller FSM with registered responses, memory request and plru pulses.
  // The compare is evaluated on the accept edge so that a hit response leaves
  // a flop during LOOKUP; the arrays cannot change between accept and LOOKUP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      core_rsp_valid  <= 1'b0;
      core_rsp_data   <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_addr    <= '0;
      req_tag_q       <= '0;
      req_word_q      <= '0;
      lookup_hit_q    <= 1'b0;
      victim_q        <= '0;
      plru_ctrl       <= '0;
    end else begin
      core_rsp_valid <= 1'b0;
      plru_ctrl      <= '0;
      if (flush && (state_q != IDLE)) begin
        flush_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (flush || flush_pending_q) begin
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
          end else if (core_req_valid) begin
            req_tag_q    <= req_tag;
            req_word_q   <= core_req_addr[3:2];
            lookup_hit_q <= hit;
            if (hit) begin
              core_rsp_valid <= 1'b1;
              core_rsp_data  <= line_word(data_q[hit_idx], core_req_addr[3:2]);
              plru_ctrl      <= '{update_tree: 1'b1, update_counter: 1'b1,
                                  cache_miss: 1'b0, hit_cl: hit_idx};
            end
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lookup_hit_q) begin
            state_q <= IDLE;
          end else begin
            victim_q      <= evicted_cl;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {req_tag_q, {LINE_OFFSET_W{1'b0}}};
            state_q       <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state_q       <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (mem_rsp_valid) begin
            valid_q[victim_q] <= 1'b1;
            core_rsp_valid    <= 1'b1;
            core_rsp_data     <= line_word(mem_rsp_data, req_word_q);
            plru_ctrl         <= '{update_tree: 1'b1, update_counter: 1'b1,
                                   cache_miss: 1'b1, hit_cl: victim_q};
            state_q           <= FILL;
          end
        end
        FILL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Line storage; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_write) begin
      tag_q[victim_q]  <= req_tag_q;
      data_q[victim_q] <= mem_rsp_data;
    end
  end

  ifu_cache_ctrl_plru plru (
    .clk        (clk),
    .rst        (rst),
    .ctrl       (plru_ctrl),
    .evicted_cl (evicted_cl)
  );

endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// Bench for ifu_cache_ctrl: directed scenarios followed by a randomized fetch
// stream, all checked against a line-level cache model whose replacement
// policy is expressed with per-way access timestamps.
module tb_ifu_cache_ctrl;

  localparam int NWAYS = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         core_req_valid = 1'b0;
  logic         core_req_ready;
  logic [31:0]  core_req_addr = '0;
  logic         core_rsp_valid;
  logic [31:0]  core_rsp_data;
  logic         mem_req_valid;
  logic         mem_req_ready = 1'b0;
  logic [31:0]  mem_req_addr;
  logic         mem_rsp_valid = 1'b0;
  logic [127:0] mem_rsp_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  bit          m_valid [NWAYS];
  logic [27:0] m_tag   [NWAYS];
  int          m_ts    [NWAYS];
  int          m_now;
  int          m_fills;

  ifu_cache_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .core_req_valid (core_req_valid),
    .core_req_ready (core_req_ready),
    .core_req_addr  (core_req_addr),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_data  (core_rsp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    n_tests++;
    n_fail++;
    $error("FAIL %s: observed timeout expected event within bound", tag);
  endtask

  function automatic logic [31:0] pat_word(input logic [31:0] line_addr, input int w);
    return 32'hC0DE_0000 ^ line_addr ^ (32'(w) << 28) ^ (32'(w) << 2);
  endfunction

  function automatic logic [127:0] pat_line(input logic [31:0] line_addr);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = pat_word(line_addr, w);
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NWAYS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_ts[i]    = 0;
    end
    m_now   = 0;
    m_fills = 0;
  endtask

  task automatic model_invalidate();
    for (int i = 0; i < NWAYS; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_touch(input int way);
    m_now++;
    m_ts[way] = m_now;
  endtask

  // Unused ways are handed out in order; afterwards, at each halving step the
  // victim lies in the half whose most recent access is older (lower half on a tie).
  function automatic int model_victim();
    int lo, size, half, ml, mr;
    if (m_fills < NWAYS) return m_fills;
    lo   = 0;
    size = NWAYS;
    while (size > 1) begin
      half = size / 2;
      ml   = 0;
      mr   = 0;
      for (int i = 0; i < half; i++) begin
        if (m_ts[lo+i] > ml) ml = m_ts[lo+i];
        if (m_ts[lo+half+i] > mr) mr = m_ts[lo+half+i];
      end
      if (ml > mr) lo += half;
      size = half;
    end
    return lo;
  endfunction

  task automatic model_lookup(input logic [27:0] tag, output bit hit, output int way);
    hit = 1'b0;
    way = 0;
    for (int i = 0; i < NWAYS; i++) begin
      if (m_valid[i] && m_tag[i] == tag) begin
        hit = 1'b1;
        way = i;
      end
    end
  endtask

  // Wait (at negedges) until the controller is ready; returns 0 on timeout.
  task automatic wait_ready(input string tag, output bit ok);
    int cyc;
    cyc = 0;
    while (core_req_ready !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    ok = (cyc < 50);
    if (!ok) timeout_fail(tag);
  endtask

  task automatic fetch(input logic [31:0] addr, input int req_lat, input int rsp_lat,
                       input bit flush_wait);
    logic [27:0] tag;
    logic [31:0] line;
    logic [31:0] exp_word;
    bit          hit;
    bit          ok;
    bit          pend;
    int          way;
    int          vic;
    tag      = addr[31:4];
    line     = {addr[31:4], 4'h0};
    exp_word = pat_word(line, int'(addr[3:2]));
    pend     = flush_wait && (rsp_lat > 0);
    model_lookup(tag, hit, way);
    @(negedge clk);
    core_req_valid = 1'b1;
    core_req_addr  = addr;
    wait_ready("req_accept", ok);
    if (!ok) begin
      core_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
    core_req_addr  = $urandom;
    @(negedge clk);
    if (hit) begin
      chk("hit_rsp_valid", core_rsp_valid, 1);
      chk("hit_rsp_data", core_rsp_data, exp_word);
      chk("hit_plru_tree", dut.plru_ctrl.update_tree, 1);
      chk("hit_plru_miss", dut.plru_ctrl.cache_miss, 0);
      chk("hit_plru_cl", dut.plru_ctrl.hit_cl, way);
      model_touch(way);
      @(negedge clk);
      chk("hit_rsp_pulse", core_rsp_valid, 0);
      chk("hit_no_memreq", mem_req_valid, 0);
      chk("hit_plru_pulse", dut.plru_ctrl.update_tree, 0);
      chk("hit_ready_back", core_req_ready, 1);
    end else begin
      chk("miss_no_rsp", core_rsp_valid, 0);
      chk("miss_no_plru", dut.plru_ctrl.update_tree, 0);
      vic = model_victim();
      @(negedge clk);
      chk("memreq_valid", mem_req_valid, 1);
      chk("memreq_addr", mem_req_addr, line);
      chk("victim", dut.victim_q, vic);
      chk("busy_ready", core_req_ready, 0);
      for (int i = 0; i < req_lat; i++) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("memreq_hold_valid", mem_req_valid, 1);
        chk("memreq_hold_addr", mem_req_addr, line);
        chk("bp_ready", core_req_ready, 0);
        chk("bp_no_rsp", core_rsp_valid, 0);
      end
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_req_ready = 1'b0;
      for (int i = 0; i < rsp_lat; i++) begin
        flush        = flush_wait && (i == 0);
        mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("wait_req_dropped", mem_req_valid, 0);
        chk("wait_no_rsp", core_rsp_valid, 0);
        chk("wait_ready", core_req_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = pat_line(line);
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("fill_rsp_valid", core_rsp_valid, 1);
      chk("fill_rsp_data", core_rsp_data, exp_word);
      chk("fill_plru_miss", dut.plru_ctrl.cache_miss, 1);
      chk("fill_plru_cntr", dut.plru_ctrl.update_counter, 1);
      chk("fill_plru_cl", dut.plru_ctrl.hit_cl, vic);
      chk("fill_ready", core_req_ready, 0);
      m_valid[vic] = 1'b1;
      m_tag[vic]   = tag;
      if (m_fills < NWAYS) m_fills++;
      model_touch(vic);
      if (pend) model_invalidate();
      @(negedge clk);
      chk("fill_rsp_pulse", core_rsp_valid, 0);
      chk("ready_after_fill", core_req_ready, pend ? 1'b0 : 1'b1);
    end
  endtask

  task automatic flush_idle(input bit with_req, input logic [31:0] addr);
    bit ok;
    @(negedge clk);
    wait_ready("flush_wait_idle", ok);
    if (!ok) return;
    flush          = 1'b1;
    core_req_valid = with_req;
    core_req_addr  = addr;
    #1;
    chk("flush_blocks_ready", core_req_ready, 0);
    @(posedge clk);
    #1;
    flush          = 1'b0;
    core_req_valid = 1'b0;
    model_invalidate();
    @(negedge clk);
    chk("flush_no_lookup", core_rsp_valid, 0);
    chk("flush_ready_back", core_req_ready, 1);
    @(negedge clk);
    chk("flush_no_memreq", mem_req_valid, 0);
    chk("flush_cleared", dut.valid_q, 0);
  endtask

  task automatic reset_mid_miss(input logic [31:0] addr);
    bit ok;
    @(negedge clk);
    core_req_valid = 1'b1;
    core_req_addr  = addr;
    wait_ready("rst_req_accept", ok);
    if (!ok) begin
      core_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    core_req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_memreq", mem_req_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_memreq_drop", mem_req_valid, 0);
    chk("rst_memreq_addr", mem_req_addr, 0);
    chk("rst_ready", core_req_ready, 1);
    chk("rst_rsp_valid", core_rsp_valid, 0);
    chk("rst_valid_bits", dut.valid_q, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    model_reset();
    #1;
    rst = 1'b0;
    #2;
    chk("reset_ready", core_req_ready, 1);
    chk("reset_rsp_valid", core_rsp_valid, 0);
    chk("reset_rsp_data", core_rsp_data, 0);
    chk("reset_memreq_valid", mem_req_valid, 0);
    chk("reset_memreq_addr", mem_req_addr, 0);
    chk("reset_valid_bits", dut.valid_q, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // cold misses fill every way once
    for (int i = 0; i < 16; i++) fetch(32'(i * 16 + (i % 4) * 4), 0, 1, 0);
    // hit on line 9 word 1
    fetch(32'h094, 0, 0, 0);
    // touch a few lines, then force an eviction and refetch the evicted line
    fetch(32'h020, 0, 0, 0);
    fetch(32'h068, 0, 0, 0);
    fetch(32'h07C, 0, 0, 0);
    fetch(32'h090, 0, 0, 0);
    fetch(32'h100, 1, 2, 0);
    fetch(32'h008, 0, 1, 0);
    // memory backpressure
    fetch(32'h1A8, 5, 3, 0);
    // flush in idle (with a colliding request), then flush during a refill
    flush_idle(1'b1, 32'h094);
    fetch(32'h094, 0, 1, 0);
    fetch(32'h0C4, 1, 2, 1);
    fetch(32'h0C4, 0, 0, 0);

    // randomized fetch stream over more lines than ways
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 11) == 0) flush_idle(1'($urandom_range(0, 1)), $urandom);
      a = {24'h0, 4'($urandom_range(0, 23)), 4'h0} | (32'($urandom_range(0, 3)) << 2);
      fetch(a, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
    end

    // reset while a miss is being requested
    reset_mid_miss(32'h3F0);
    fetch(32'h094, 0, 1, 0);
    fetch(32'h3F4, 0, 1, 0);
    fetch(32'h3F8, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
